// File: rtl/core_param_loader.sv
// -----------------------------------------------------------------------------
// core_param_loader
//
// Loads neuron parameter words or neuron instruction codes from a
// valid/ready configuration stream into the core's memories. A command
// (cfg_start with mode, base and count) selects the target memory and the
// address range. Beats are assembled into entries, and each entry is written
// with a single one-cycle write-enable pulse. The load ends with a one-cycle
// done pulse. An illegal command produces a one-cycle error pulse.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cfg_start             one-cycle load request (mode/base/count sampled)
//   cfg_mode              0 = neuron parameter, 1 = neuron instruction
//   cfg_base              first neuron address
//   cfg_count             number of entries, legal range 1..2**ADDR_W
//   cfg_abort             cancels a load in progress
//   s_valid/s_ready       stream handshake, s_data = stream payload
//   param_*               neuron parameter memory write port
//   neuron_inst_*         neuron instruction memory write port
//   busy                  high whenever the loader is not idle
//   done                  one-cycle pulse when a load completes
//   error                 one-cycle pulse on an illegal command
// -----------------------------------------------------------------------------
module core_param_loader #(
   parameter int DATA_W  = 32,
   parameter int PARAM_W = 368,
   parameter int ADDR_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic               cfg_mode,
   input  logic [ADDR_W-1:0]  cfg_base,
   input  logic [ADDR_W:0]    cfg_count,
   input  logic               cfg_abort,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   output logic               param_wen,
   output logic [ADDR_W-1:0]  param_address,
   output logic [PARAM_W-1:0] param_data_in,
   output logic               neuron_inst_wen,
   output logic [ADDR_W-1:0]  neuron_inst_address,
   output logic [1:0]         neuron_inst_data_in,
   output logic               busy,
   output logic               done,
   output logic               error
);

   // Beats per parameter entry; the last beat carries only the remaining bits.
   localparam int BEATS   = (PARAM_W + DATA_W - 1) / DATA_W;
   localparam int LAST_LO = (BEATS - 1) * DATA_W;
   localparam int LAST_W  = PARAM_W - LAST_LO;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_mode;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W:0]     r_index;
   logic [BEAT_W-1:0]   r_beat;
   logic [PARAM_W-1:0]  r_asm;
   logic [ADDR_W-1:0]   r_param_address;
   logic [PARAM_W-1:0]  r_param_data;
   logic [ADDR_W-1:0]   r_inst_address;
   logic [1:0]          r_inst_data;
   logic                r_error;

   logic                w_fire;
   logic                w_last_beat;
   logic                w_start_ok;
   logic [ADDR_W:0]     w_index_inc;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic [PARAM_W-1:0]  w_asm_next;

   assign w_fire      = s_valid & (r_state == S_COLLECT);
   // Instruction entries are a single beat, so every accepted beat is the last.
   assign w_last_beat = r_mode | (r_beat == LAST_BEAT);
   assign w_start_ok  = cfg_start & (r_state == S_IDLE)
                        & (cfg_count != '0) & (cfg_count <= MAX_COUNT);
   assign w_index_inc = r_index + (ADDR_W+1)'(1);
   // Address arithmetic is ADDR_W wide, so base + index wraps past the top.
   assign w_wr_addr   = r_base + r_index[ADDR_W-1:0];

   // Assembly word with the current beat merged in. The last beat of a
   // parameter entry contributes only its low LAST_W bits.
   always_comb begin
      // NOTE: every combinational output is given a default first so that no
      // path through the block leaves it unassigned (which would infer a latch).
      w_asm_next = r_asm;
      for (int k = 0; k < BEATS - 1; k++) begin
         if (r_beat == BEAT_W'(k)) w_asm_next[k*DATA_W +: DATA_W] = s_data;
      end
      if (r_beat == LAST_BEAT) w_asm_next[PARAM_W-1:LAST_LO] = s_data[LAST_W-1:0];
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_ok) w_state_next = S_COLLECT;
         S_COLLECT: begin
            if (cfg_abort)                  w_state_next = S_IDLE;
            else if (w_fire && w_last_beat) w_state_next = S_WRITE;
         end
         S_WRITE: begin
            if (cfg_abort)                   w_state_next = S_IDLE;
            else if (w_index_inc == r_count) w_state_next = S_DONE;
            else                             w_state_next = S_COLLECT;
         end
         S_DONE:    w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the wide assembly and data registers are cleared here because
         // the write-port outputs must read 0 straight after reset; they are
         // plain flops, not a memory array, so a reset costs no RAM inference.
         r_mode          <= 1'b0;
         r_base          <= '0;
         r_count         <= '0;
         r_index         <= '0;
         r_beat          <= '0;
         r_asm           <= '0;
         r_param_address <= '0;
         r_param_data    <= '0;
         r_inst_address  <= '0;
         r_inst_data     <= '0;
         r_error         <= 1'b0;
      end else begin
         // Any start that is not an accepted IDLE command is illegal.
         r_error <= cfg_start & ~w_start_ok;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_mode  <= cfg_mode;
                  r_base  <= cfg_base;
                  r_count <= cfg_count;
                  r_index <= '0;
                  r_beat  <= '0;
               end
            end
            S_COLLECT: begin
               if (cfg_abort) begin
                  r_beat <= '0;
               end else if (w_fire) begin
                  r_asm <= w_asm_next;
                  if (w_last_beat) begin
                     // Address and data are captured here, one cycle before
                     // the wen pulse, and then held until the next entry.
                     r_beat <= '0;
                     if (r_mode) begin
                        r_inst_address <= w_wr_addr;
                        r_inst_data    <= s_data[1:0];
                     end else begin
                        r_param_address <= w_wr_addr;
                        r_param_data    <= w_asm_next;
                     end
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            S_WRITE:  if (!cfg_abort) r_index <= w_index_inc;
            default:  ;
         endcase
      end
   end

   assign s_ready             = (r_state == S_COLLECT);
   assign busy                = (r_state != S_IDLE);
   assign done                = (r_state == S_DONE);
   assign param_wen           = (r_state == S_WRITE) & ~r_mode;
   assign neuron_inst_wen     = (r_state == S_WRITE) &  r_mode;
   assign param_address       = r_param_address;
   assign param_data_in       = r_param_data;
   assign neuron_inst_address = r_inst_address;
   assign neuron_inst_data_in = r_inst_data;
   assign error               = r_error;

endmodule

// File: tb/tb_core_param_loader.sv
// -----------------------------------------------------------------------------
// tb_core_param_loader
//
// Self-checking bench for core_param_loader. Random stream payloads are
// driven for parameter and instruction loads; a monitor records every write
// pulse, and the expected write list (address, data) is computed per entry
// from the load command and the beats sent.
// -----------------------------------------------------------------------------
module tb_core_param_loader;

   localparam int DATA_W  = 32;
   localparam int PARAM_W = 368;
   localparam int ADDR_W  = 8;

   typedef struct {
      bit                 mode;
      logic [ADDR_W-1:0]  addr;
      logic [PARAM_W-1:0] data;
   } wr_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_start;
   logic               cfg_mode;
   logic [ADDR_W-1:0]  cfg_base;
   logic [ADDR_W:0]    cfg_count;
   logic               cfg_abort;
   logic               s_valid;
   logic               s_ready;
   logic [DATA_W-1:0]  s_data;
   logic               param_wen;
   logic [ADDR_W-1:0]  param_address;
   logic [PARAM_W-1:0] param_data_in;
   logic               neuron_inst_wen;
   logic [ADDR_W-1:0]  neuron_inst_address;
   logic [1:0]         neuron_inst_data_in;
   logic               busy;
   logic               done;
   logic               error;

   int                 n_checks = 0;
   int                 n_fail   = 0;
   int                 n_done   = 0;
   int                 n_err    = 0;
   bit                 prev_done = 1'b0;
   wr_t                obs[$];
   logic [DATA_W-1:0]  beats[$];
   logic [PARAM_W-1:0] first_data;

   core_param_loader #(
      .DATA_W (DATA_W),
      .PARAM_W(PARAM_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .cfg_start          (cfg_start),
      .cfg_mode           (cfg_mode),
      .cfg_base           (cfg_base),
      .cfg_count          (cfg_count),
      .cfg_abort          (cfg_abort),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_data             (s_data),
      .param_wen          (param_wen),
      .param_address      (param_address),
      .param_data_in      (param_data_in),
      .neuron_inst_wen    (neuron_inst_wen),
      .neuron_inst_address(neuron_inst_address),
      .neuron_inst_data_in(neuron_inst_data_in),
      .busy               (busy),
      .done               (done),
      .error              (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor, sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (param_wen || neuron_inst_wen) begin
         wr_t w;
         check("wen_exclusive_sready_low", {param_wen & neuron_inst_wen, s_ready}, 2'b00);
         w.mode = neuron_inst_wen;
         w.addr = neuron_inst_wen ? neuron_inst_address : param_address;
         w.data = neuron_inst_wen ? PARAM_W'(neuron_inst_data_in) : param_data_in;
         obs.push_back(w);
      end
      if (prev_done) check("busy_low_after_done", busy, 1'b0);
      if (done === 1'b1)  n_done++;
      if (error === 1'b1) n_err++;
      prev_done = (done === 1'b1);
   end

   // Expected parameter word of entry e: 32-bit beats low to high, last beat
   // contributing its low 16 bits only.
   function automatic logic [PARAM_W-1:0] pack_entry(input int e);
      logic [PARAM_W-1:0] d;
      logic [DATA_W-1:0]  b;
      d = '0;
      for (int k = 0; k < 11; k++) begin
         b = beats[e*12 + k];
         d[32*k +: 32] = b;
      end
      b = beats[e*12 + 11];
      d[367:352] = b[15:0];
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load command plus its stream. vmode: 0 always valid, 1 alternate,
   // 2 random. pattern: 0 random, 1 beat index, 2 (index+1) in low bits.
   // abort_at / start_at / reset_at: number of beats sent before the event
   // (-1 = none).
   task automatic run_load(input bit mode, input logic [ADDR_W-1:0] base, input int count,
                           input int pattern, input int vmode, input int abort_at,
                           input int start_at, input int reset_at, input bit abort_on_start);
      int  bpe, total, sent, cyc, exp_n, budget;
      bit  stop, dup_done, xfer;
      logic [DATA_W-1:0] b;
      bpe    = mode ? 1 : 12;
      total  = count * bpe;
      budget = total * 6 + 100;
      beats.delete();
      for (int i = 0; i < total; i++) begin
         case (pattern)
            0:       beats.push_back($urandom);
            1:       beats.push_back(DATA_W'(i));
            default: beats.push_back((DATA_W'(i + 1) & 32'h3) | ($urandom & 32'hFFFF_FFFC));
         endcase
      end

      cfg_start = 1'b1;
      cfg_mode  = mode;
      cfg_base  = base;
      cfg_count = (ADDR_W+1)'(count);
      cfg_abort = abort_on_start;
      tick();
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      check("start_busy", busy, 1'b1);

      sent = 0; cyc = 0; stop = 1'b0; dup_done = 1'b0;
      while (sent < total && cyc < budget && !stop) begin
         if (abort_at >= 0 && sent == abort_at) begin
            s_valid   = 1'b1;
            s_data    = beats[sent];
            cfg_abort = 1'b1;
            tick();
            cfg_abort = 1'b0;
            s_valid   = 1'b0;
            check("abort_idle_next_cycle", {busy, s_ready, done}, 3'b000);
            stop = 1'b1;
         end else if (reset_at >= 0 && sent == reset_at) begin
            s_valid = 1'b1;
            s_data  = beats[sent];
            reset   = 1'b1;
            tick();
            reset   = 1'b0;
            check("reset_ctrl_outputs", {param_wen, neuron_inst_wen, busy, done, error, s_ready,
                                         param_address, neuron_inst_address, neuron_inst_data_in}, '0);
            check("reset_param_data", param_data_in, '0);
            // Keep offering beats: an idle loader must not write anything.
            repeat (20) tick();
            s_valid = 1'b0;
            stop = 1'b1;
         end else begin
            case (vmode)
               0:       s_valid = 1'b1;
               1:       s_valid = (cyc % 2 == 0);
               default: s_valid = ($urandom % 4) != 0;
            endcase
            s_data = beats[sent];
            if (start_at >= 0 && sent == start_at && !dup_done) begin
               cfg_start = 1'b1;
               cfg_mode  = ~mode;
               cfg_base  = base + 8'h40;
               cfg_count = 9'd5;
               dup_done  = 1'b1;
            end
            xfer = s_valid && s_ready;
            tick();
            cfg_start = 1'b0;
            if (xfer) sent++;
            cyc++;
         end
      end
      s_valid = 1'b0;

      if (!stop) begin
         check("stream_beats_accepted", sent, total);
         cyc = 0;
         while (busy && cyc < 60) begin
            tick();
            cyc++;
         end
         check("load_returns_idle", busy, 1'b0);
      end
      repeat (3) tick();

      if (abort_at >= 0)      exp_n = abort_at / bpe;
      else if (reset_at >= 0) exp_n = reset_at / bpe;
      else                    exp_n = count;

      check("write_count", obs.size(), exp_n);
      for (int e = 0; e < exp_n && e < obs.size(); e++) begin
         check("write_mode", obs[e].mode, mode);
         check("write_addr", obs[e].addr, ADDR_W'(base + e));
         b = beats[e];
         check("write_data", obs[e].data, mode ? PARAM_W'(b[1:0]) : pack_entry(e));
      end
      check("done_pulses", n_done, (abort_at >= 0 || reset_at >= 0) ? 0 : 1);
      check("error_pulses", n_err, (start_at >= 0) ? 1 : 0);
      first_data = (obs.size() > 0) ? obs[0].data : '0;
      obs.delete();
      n_done = 0;
      n_err  = 0;
   endtask

   task automatic bad_start(input int count);
      cfg_start = 1'b1;
      cfg_mode  = 1'($urandom);
      cfg_base  = 8'($urandom);
      cfg_count = (ADDR_W+1)'(count);
      tick();
      cfg_start = 1'b0;
      check("bad_count_error", error, 1'b1);
      check("bad_count_busy", busy, 1'b0);
      tick();
      check("bad_count_error_one_cycle", {error, busy}, 2'b00);
      repeat (2) tick();
      check("bad_count_no_write", obs.size(), 0);
      n_err  = 0;
      n_done = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cfg_start = 1'b0;
      cfg_mode  = 1'b0;
      cfg_base  = '0;
      cfg_count = '0;
      cfg_abort = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      repeat (3) tick();
      check("reset_state_ctrl", {param_wen, neuron_inst_wen, busy, done, error, s_ready,
                                 param_address, neuron_inst_address, neuron_inst_data_in}, '0);
      check("reset_state_data", param_data_in, '0);
      reset = 1'b0;
      tick();
      n_done = 0;
      n_err  = 0;

      // Parameter load, beat value = beat index.
      run_load(1'b0, 8'h10, 2, 1, 0, -1, -1, -1, 1'b0);
      check("param_top_bits", first_data[367:352], 16'h000B);

      // Instruction load wrapping past address 255.
      run_load(1'b1, 8'hFE, 4, 2, 0, -1, -1, -1, 1'b0);

      // Back-pressure: valid every other cycle.
      run_load(1'b0, 8'h33, 1, 0, 1, -1, -1, -1, 1'b0);

      // Illegal counts in IDLE.
      bad_start(0);
      bad_start(257);
      bad_start(511);

      // cfg_start while busy: error pulse, load unchanged.
      run_load(1'b0, 8'h20, 2, 0, 2, -1, 7, -1, 1'b0);
      run_load(1'b1, 8'h80, 6, 0, 0, -1, 3, -1, 1'b0);

      // Abort after beat 5 of entry 1, then a legal load.
      run_load(1'b0, 8'h40, 3, 0, 0, 18, -1, -1, 1'b0);
      run_load(1'b0, 8'h41, 1, 0, 0, -1, -1, -1, 1'b0);

      // Abort together with start in IDLE: start wins.
      run_load(1'b1, 8'h05, 5, 0, 2, -1, -1, -1, 1'b1);

      // Reset in the middle of entry 1.
      run_load(1'b0, 8'h50, 2, 0, 0, -1, -1, 15, 1'b0);

      // Maximum count.
      run_load(1'b1, 8'hC3, 256, 0, 0, -1, -1, -1, 1'b0);

      // Randomized loads.
      for (int i = 0; i < 8; i++) begin
         bit m;
         int c;
         m = 1'($urandom);
         c = m ? 1 + int'($urandom % 40) : 1 + int'($urandom % 3);
         run_load(m, 8'($urandom), c, 0, 2, -1, -1, -1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_param_loader.md
CORE_PARAM_LOADER -- requirements
Module: core_param_loader

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, width of the config stream; PARAM_W, default 368, neuron parameter word width; ADDR_W, default 8, neuron address width (256 neurons).
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 cfg_start  input  1  one-cycle request to begin a load.
REQ-005 cfg_mode  input  1  target memory: 0 = neuron parameter, 1 = neuron instruction; sampled with cfg_start.
REQ-006 cfg_base  input  ADDR_W  first neuron address; sampled with cfg_start.
REQ-007 cfg_count  input  ADDR_W+1  number of entries, 1..256; sampled with cfg_start.
REQ-008 cfg_abort  input  1  cancels an in-progress load.
REQ-009 s_valid / s_ready  input / output  1 / 1  stream handshake; a beat transfers when both are 1.
REQ-010 s_data  input  DATA_W  stream payload.
REQ-011 param_wen, param_address, param_data_in  output  1, ADDR_W, PARAM_W  neuron parameter memory write port.
REQ-012 neuron_inst_wen, neuron_inst_address, neuron_inst_data_in  output  1, ADDR_W, 2  neuron instruction memory write port.
REQ-013 busy  output  1  high in every state except IDLE; the system SHALL hold tick low while busy is high.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 error  output  1  one-cycle pulse on an illegal command.

Function
REQ-016 The FSM SHALL have four states: IDLE, COLLECT, WRITE and DONE.
REQ-017 IDLE: cfg_start with cfg_count in 1..256 SHALL latch mode, base and count, clear the entry index and beat counter, and go to COLLECT next cycle.
REQ-018 IDLE: cfg_start with cfg_count = 0 or cfg_count > 256 SHALL pulse error the next cycle and remain in IDLE.
REQ-019 cfg_start in any state other than IDLE SHALL pulse error the next cycle and SHALL NOT change the operation in progress.
REQ-020 COLLECT SHALL drive s_ready = 1; every other state SHALL drive s_ready = 0.
REQ-021 Parameter mode SHALL take 12 beats per entry: beat k (0..10) fills param bits [32k+31:32k]; beat 11 fills bits [367:352] from s_data[15:0]; s_data[31:16] of beat 11 SHALL be ignored.
REQ-022 Instruction mode SHALL take 1 beat per entry; data = s_data[1:0], upper bits ignored.
REQ-023 The cycle after the final beat of an entry is accepted, the FSM SHALL be in WRITE and assert exactly one wen pulse (param_wen or neuron_inst_wen per mode) for one cycle.
REQ-024 Write address SHALL be (base + index) mod 256; wrap past 255 to 0 is legal and SHALL NOT be flagged.
REQ-025 Address and data outputs SHALL be stable during the wen cycle; outside wen cycles they hold their last value.
REQ-026 After WRITE, the index SHALL increment; if index = count, the FSM SHALL go to DONE, otherwise back to COLLECT with the beat counter at 0.
REQ-027 DONE SHALL assert done for exactly one cycle, then go to IDLE; busy SHALL fall in the same cycle as the move to IDLE.
REQ-028 cfg_abort in COLLECT, WRITE or DONE SHALL move to IDLE next cycle.
REQ-029 An abort SHALL suppress a pending WRITE (no wen) and SHALL suppress done.
REQ-030 An abort SHALL discard partial beats; entries already written SHALL remain written.
REQ-031 cfg_abort in IDLE SHALL have no effect; if cfg_abort and cfg_start are both high in IDLE, cfg_start SHALL win.
REQ-032 Beat throughput: 1 beat per cycle in COLLECT. Per-entry cost: parameter mode 13 cycles minimum (12 beats + WRITE); instruction mode 2 cycles.

Reset
REQ-033 While reset is high, the FSM SHALL go to IDLE, counters and the assembly register SHALL clear, and all outputs SHALL be 0 on the next edge.
REQ-034 Reset mid-load SHALL abandon the load with no wen and no done.

Verification
REQ-035 Parameter load: mode 0, base 0x10, count 2, 24 beats with s_data = beat index -> param_wen at 0x10 and 0x11; data word 0 beats 0..11 packed, bits [367:352] = 0x000B; done pulses once.
REQ-036 Instruction wrap: mode 1, base 0xFE, count 4, data 1,2,3,0 -> neuron_inst_wen at 0xFE, 0xFF, 0x00, 0x01 with those values; no error.
REQ-037 Back-pressure: s_valid toggles every other cycle in mode 0, count 1 -> exactly one param_wen with correct data; s_ready = 0 during WRITE.
REQ-038 Illegal commands: count 0 -> error pulse and busy stays 0; cfg_start while busy -> error pulse and the current load completes unchanged.
REQ-039 Abort: in mode 0, assert cfg_abort after beat 5 of entry 1 -> no further wen, no done, IDLE next cycle; a following legal load succeeds.
REQ-040 Reset mid-load: assert reset for one cycle during COLLECT -> all outputs 0 and busy 0 next cycle; no wen after reset deasserts.
